// File: rtl/tpm_ram_pkg.sv
// Shared types and constants for the TPM buffer RAM arbiter.
package tpm_ram_pkg;

  localparam int unsigned RamWordAddrWidth = 9;
  localparam int unsigned RamDataWidth     = 32;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StAck
  } state_e;

  typedef enum logic {
    GntDp,
    GntMcu
  } grant_e;

endpackage

// File: rtl/tpm_byte_lane.sv
// Byte-lane steering between the 8-bit DP port and the 32-bit RAM word (little-endian).
module tpm_byte_lane
  import tpm_ram_pkg::*;
(
  input  logic [1:0]              lane_i,
  input  logic [7:0]              wr_byte_i,
  input  logic [RamDataWidth-1:0] rd_word_i,
  output logic [3:0]              be_o,
  output logic [RamDataWidth-1:0] wd_o,
  output logic [7:0]              rd_byte_o
);

  always_comb begin
    be_o      = 4'b0001 << lane_i;
    wd_o      = {4{wr_byte_i}};
    rd_byte_o = rd_word_i[8*lane_i +: 8];
  end

endmodule

// File: rtl/tpm_ram_arbiter.sv
// Round-robin arbiter sharing the 512x32 TPM buffer RAM between the LPC DP and the M4 bus.
// Each transaction walks Idle -> Access -> Ack, so acks arrive two cycles after the grant.
module tpm_ram_arbiter
  import tpm_ram_pkg::*;
#(
  parameter int unsigned RamAddrWidth = 11,
  parameter int unsigned DataWidth    = RamDataWidth
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [RamAddrWidth-1:0]     dp_addr_i,
  input  logic [7:0]                  dp_data_i,
  output logic [7:0]                  dp_data_o,
  input  logic                        dp_req_i,
  input  logic                        dp_we_i,
  output logic                        dp_ack_o,
  input  logic [RamWordAddrWidth-1:0] mcu_addr_i,
  input  logic [DataWidth-1:0]        mcu_data_i,
  output logic [DataWidth-1:0]        mcu_data_o,
  input  logic [3:0]                  mcu_be_i,
  input  logic                        mcu_req_i,
  input  logic                        mcu_we_i,
  output logic                        mcu_ack_o,
  output logic [RamWordAddrWidth-1:0] ram_addr_o,
  output logic [DataWidth-1:0]        ram_wd_o,
  output logic [3:0]                  ram_be_o,
  output logic                        ram_we_o,
  input  logic [DataWidth-1:0]        ram_rd_i
);

  state_e                      state_q;
  grant_e                      gnt_q, last_grant_q, gnt_d;
  logic                        we_q;
  logic [1:0]                  lane_q, lane_sel;
  logic [RamWordAddrWidth-1:0] ram_addr_q;
  logic [DataWidth-1:0]        ram_wd_q;
  logic [3:0]                  ram_be_q;
  logic                        ram_we_q;
  logic                        dp_ack_q, mcu_ack_q;
  logic [7:0]                  dp_data_q;
  logic [DataWidth-1:0]        mcu_data_q;
  logic [3:0]                  lane_be;
  logic [DataWidth-1:0]        lane_wd;
  logic [7:0]                  lane_rd;

  // The DP lane comes straight from the port while granting, then from the latched copy.
  assign lane_sel = (state_q == StIdle) ? dp_addr_i[1:0] : lane_q;

  tpm_byte_lane u_byte_lane (
    .lane_i    (lane_sel),
    .wr_byte_i (dp_data_i),
    .rd_word_i (ram_rd_i),
    .be_o      (lane_be),
    .wd_o      (lane_wd),
    .rd_byte_o (lane_rd)
  );

  always_comb begin
    gnt_d = GntDp;
    if (mcu_req_i && (!dp_req_i || last_grant_q == GntDp)) begin
      gnt_d = GntMcu;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      gnt_q        <= GntMcu;
      last_grant_q <= GntMcu;
      we_q         <= 1'b0;
      lane_q       <= '0;
      ram_addr_q   <= '0;
      ram_wd_q     <= '0;
      ram_be_q     <= '0;
      ram_we_q     <= 1'b0;
      dp_ack_q     <= 1'b0;
      mcu_ack_q    <= 1'b0;
      dp_data_q    <= '0;
      mcu_data_q   <= '0;
    end else begin
      dp_ack_q  <= 1'b0;
      mcu_ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (dp_req_i || mcu_req_i) begin
            state_q      <= StAccess;
            gnt_q        <= gnt_d;
            last_grant_q <= gnt_d;
            if (gnt_d == GntDp) begin
              we_q       <= dp_we_i;
              lane_q     <= dp_addr_i[1:0];
              ram_addr_q <= dp_addr_i[RamAddrWidth-1:2];
              ram_wd_q   <= lane_wd;
              ram_be_q   <= dp_we_i ? lane_be : 4'b0000;
              ram_we_q   <= dp_we_i;
            end else begin
              we_q       <= mcu_we_i;
              ram_addr_q <= mcu_addr_i;
              ram_wd_q   <= mcu_data_i;
              ram_be_q   <= mcu_we_i ? mcu_be_i : 4'b0000;
              // An all-zero byte mask completes without strobing the RAM.
              ram_we_q   <= mcu_we_i && (mcu_be_i != 4'b0000);
            end
          end
        end
        StAccess: begin
          state_q   <= StAck;
          ram_be_q  <= '0;
          ram_we_q  <= 1'b0;
          dp_ack_q  <= (gnt_q == GntDp);
          mcu_ack_q <= (gnt_q == GntMcu);
        end
        StAck: begin
          state_q <= StIdle;
          if (!we_q) begin
            if (gnt_q == GntDp) dp_data_q <= lane_rd;
            else                mcu_data_q <= ram_rd_i;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data is live from the RAM during the ack cycle and held afterwards.
  always_comb begin
    dp_data_o  = dp_data_q;
    mcu_data_o = mcu_data_q;
    if (state_q == StAck && !we_q) begin
      if (gnt_q == GntDp) dp_data_o = lane_rd;
      else                mcu_data_o = ram_rd_i;
    end
  end

  assign ram_addr_o = ram_addr_q;
  assign ram_wd_o   = ram_wd_q;
  assign ram_be_o   = ram_be_q;
  assign ram_we_o   = ram_we_q;
  assign dp_ack_o   = dp_ack_q;
  assign mcu_ack_o  = mcu_ack_q;

endmodule

// File: tb/tb_tpm_ram_arbiter.sv
// Directed bench for tpm_ram_arbiter with a behavioural synchronous 512x32 RAM.
module tb_tpm_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] dp_addr;
  logic [7:0]  dp_wdata, dp_rdata;
  logic        dp_req, dp_we, dp_ack;
  logic [8:0]  mcu_addr;
  logic [31:0] mcu_wdata, mcu_rdata;
  logic [3:0]  mcu_be;
  logic        mcu_req, mcu_we, mcu_ack;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wd, ram_rd;
  logic [3:0]  ram_be;
  logic        ram_we;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tpm_ram_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .dp_addr_i  (dp_addr),
    .dp_data_i  (dp_wdata),
    .dp_data_o  (dp_rdata),
    .dp_req_i   (dp_req),
    .dp_we_i    (dp_we),
    .dp_ack_o   (dp_ack),
    .mcu_addr_i (mcu_addr),
    .mcu_data_i (mcu_wdata),
    .mcu_data_o (mcu_rdata),
    .mcu_be_i   (mcu_be),
    .mcu_req_i  (mcu_req),
    .mcu_we_i   (mcu_we),
    .mcu_ack_o  (mcu_ack),
    .ram_addr_o (ram_addr),
    .ram_wd_o   (ram_wd),
    .ram_be_o   (ram_be),
    .ram_we_o   (ram_we),
    .ram_rd_i   (ram_rd)
  );

  // Power-up contents of each RAM word until it is first written.
  function automatic logic [31:0] init_word(input int i);
    logic [31:0] iw;
    iw = 32'(i);
    return 32'h5A00_0000 | (iw << 8) | (iw & 32'hFF);
  endfunction

  logic [31:0] mem  [512];
  bit          wr_v [512];

  always @(posedge clk) begin : ram_model
    logic [31:0] w;
    w = wr_v[ram_addr] ? mem[ram_addr] : init_word(int'(ram_addr));
    ram_rd <= w;
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) w[8*b +: 8] = ram_wd[8*b +: 8];
      end
      mem[ram_addr]  <= w;
      wr_v[ram_addr] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          mcu;
    bit          we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [8:0]  e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
    bit          e_we;
    logic [31:0] e_rd;   // read result, or the held value for writes
  } vec_t;

  localparam int NVec = 12;
  vec_t v [NVec];

  task automatic run_vec(input vec_t t);
    @(negedge clk);
    if (t.mcu) begin
      mcu_addr = t.addr[8:0]; mcu_wdata = t.wdata; mcu_be = t.be; mcu_we = t.we; mcu_req = 1'b1;
    end else begin
      dp_addr = t.addr; dp_wdata = t.wdata[7:0]; dp_we = t.we; dp_req = 1'b1;
    end
    @(negedge clk);
    chk("acc_addr", 32'(ram_addr), 32'(t.e_addr));
    chk("acc_be", 32'(ram_be), 32'(t.e_be));
    chk("acc_we", 32'(ram_we), 32'(t.e_we));
    if (t.we) chk("acc_wd", ram_wd, t.e_wd);
    chk("acc_noack", 32'({dp_ack, mcu_ack}), 32'd0);
    @(negedge clk);
    chk("ack", 32'({dp_ack, mcu_ack}), t.mcu ? 32'd1 : 32'd2);
    chk("ack_we_be", 32'({ram_we, ram_be}), 32'd0);
    if (t.mcu) chk("mcu_data", mcu_rdata, t.e_rd);
    else       chk("dp_data", 32'(dp_rdata), t.e_rd);
    dp_req  = 1'b0;
    mcu_req = 1'b0;
  endtask

  function automatic logic [31:0] final_word(input int i);
    if (i == 3)       return 32'h1122_3344;
    if (i == 9'h1FF)  return 32'h7EBB_FFDD;
    return init_word(i);
  endfunction

  initial begin
    int n;
    //      mcu we  addr     wdata         be       e_addr  e_wd          e_be     e_we e_rd
    v[0]  = '{0, 1, 11'h00D, 32'h0000_00A5, 4'b0000, 9'h003, 32'hA5A5_A5A5, 4'b0010, 1, 32'h03};
    v[1]  = '{1, 1, 11'h003, 32'h1122_3344, 4'b1111, 9'h003, 32'h1122_3344, 4'b1111, 1,
              32'h5A00_0000};
    v[2]  = '{0, 0, 11'h00E, 32'h0,         4'b0000, 9'h003, 32'h0,         4'b0000, 0, 32'h22};
    v[3]  = '{0, 0, 11'h00F, 32'h0,         4'b0000, 9'h003, 32'h0,         4'b0000, 0, 32'h11};
    v[4]  = '{0, 0, 11'h00C, 32'h0,         4'b0000, 9'h003, 32'h0,         4'b0000, 0, 32'h44};
    v[5]  = '{1, 1, 11'h1FF, 32'hAABB_CCDD, 4'b0101, 9'h1FF, 32'hAABB_CCDD, 4'b0101, 1,
              32'h5A00_0000};
    v[6]  = '{1, 0, 11'h1FF, 32'h0,         4'b0000, 9'h1FF, 32'h0,         4'b0000, 0,
              32'h5ABB_FFDD};
    v[7]  = '{0, 1, 11'h7FF, 32'h0000_007E, 4'b0000, 9'h1FF, 32'h7E7E_7E7E, 4'b1000, 1, 32'h44};
    v[8]  = '{1, 0, 11'h1FF, 32'h0,         4'b0000, 9'h1FF, 32'h0,         4'b0000, 0,
              32'h7EBB_FFDD};
    v[9]  = '{1, 1, 11'h003, 32'hFFFF_FFFF, 4'b0000, 9'h003, 32'hFFFF_FFFF, 4'b0000, 0,
              32'h7EBB_FFDD};
    v[10] = '{1, 0, 11'h003, 32'h0,         4'b0000, 9'h003, 32'h0,         4'b0000, 0,
              32'h1122_3344};
    v[11] = '{0, 0, 11'h1FD, 32'h0,         4'b0000, 9'h07F, 32'h0,         4'b0000, 0, 32'h7F};

    rst = 1'b1;
    dp_addr = '0; dp_wdata = '0; dp_req = 1'b0; dp_we = 1'b0;
    mcu_addr = '0; mcu_wdata = '0; mcu_be = '0; mcu_req = 1'b0; mcu_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram", {ram_addr, ram_be, ram_we, 18'd0}, 32'd0);
    chk("rst_wd", ram_wd, 32'd0);
    chk("rst_acks", 32'({dp_ack, mcu_ack}), 32'd0);
    chk("rst_data", mcu_rdata | 32'(dp_rdata), 32'd0);
    rst = 1'b0;

    // Simultaneous requests out of reset, both held: DP first, then strict alternation.
    dp_addr = 11'h00D; dp_we = 1'b0; dp_req = 1'b1;
    mcu_addr = 9'h000; mcu_we = 1'b0; mcu_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("tie_c%0d", k), 32'({dp_ack, mcu_ack}),
          (k == 2 || k == 8) ? 32'd2 : (k == 5 || k == 11) ? 32'd1 : 32'd0);
      if (k == 8) chk("tie_dp_data", 32'(dp_rdata), 32'h03);
      if (k == 11) chk("tie_mcu_data", mcu_rdata, 32'h5A00_0000);
    end
    dp_req = 1'b0; mcu_req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVec; i++) run_vec(v[i]);

    // Reset lands during the Access cycle of a DP read.
    @(negedge clk);
    dp_addr = 11'h00E; dp_we = 1'b0; dp_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_acks", 32'({dp_ack, mcu_ack}), 32'd0);
    chk("midrst_ram", {ram_addr, ram_be, ram_we, 18'd0}, 32'd0);
    chk("midrst_wd", ram_wd, 32'd0);
    chk("midrst_data", mcu_rdata | 32'(dp_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rereq_noack", 32'(dp_ack), 32'd0);
    @(negedge clk);
    chk("rereq_ack", 32'(dp_ack), 32'd1);
    chk("rereq_data", 32'(dp_rdata), 32'h22);
    dp_req = 1'b0;
    @(negedge clk);

    // Back-to-back MCU reads across the whole word range.
    mcu_addr = 9'h000; mcu_we = 1'b0; mcu_be = 4'b0000; mcu_req = 1'b1;
    for (int i = 0; i < 512; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!mcu_ack && n < 8);
      chk($sformatf("sweep_gap_%0d", i), 32'(n), (i == 0) ? 32'd2 : 32'd3);
      chk($sformatf("sweep_data_%0d", i), mcu_rdata, final_word(i));
      mcu_addr = 9'(i + 1);
    end
    mcu_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tpm_ram_arbiter.md
Name: tpm_ram_arbiter

Overview:
- Shares the single 512x32 TPM buffer RAM between two requesters:
  - the LPC data provider, which makes byte-wide accesses with an 11-bit byte address;
  - the M4 bus side, which makes 32-bit accesses with byte enables and a 9-bit word address.
- Sits between regs_module and the RAM block, and drives RAM_A / RAM_WD / RAM_byte_sel.
- Arbitration is round-robin. Each requester sees a request/ack handshake with fixed latency.

Parameters:
- RAM_ADDR_WIDTH, 11, DP byte-address width; word address = RAM_ADDR_WIDTH-2 = 9 bits
- DATA_WIDTH, 32, RAM word width; must be 32

Ports:
- clk_i  input  1  single clock (LCLK domain)
- rst_i  input  1  synchronous reset, active-high
- dp_addr_i  input  11  DP byte address
- dp_data_i  input  8  DP write byte
- dp_data_o  output  8  DP read byte, valid while dp_ack_o=1
- dp_req_i  input  1  DP request, level, held until ack
- dp_we_i  input  1  1=write, 0=read; stable while dp_req_i=1
- dp_ack_o  output  1  one-cycle completion pulse
- mcu_addr_i  input  9  MCU word address
- mcu_data_i  input  32  MCU write word
- mcu_data_o  output  32  MCU read word, valid while mcu_ack_o=1
- mcu_be_i  input  4  MCU byte enables, bit n = bits 8n+7:8n
- mcu_req_i  input  1  MCU request, level, held until ack
- mcu_we_i  input  1  1=write
- mcu_ack_o  output  1  one-cycle completion pulse
- ram_addr_o  output  9  RAM word address
- ram_wd_o  output  32  RAM write data
- ram_be_o  output  4  RAM byte write enables
- ram_we_o  output  1  RAM write strobe
- ram_rd_i  input  32  RAM read data, synchronous, valid one cycle after address

Behaviour:
- FSM states:
  - IDLE: sample requests and pick a winner.
  - ACCESS: RAM driven with the winner's address, data and enables for exactly one cycle.
  - ACK: ack pulse to the winner; read data muxed from ram_rd_i.
  - Transitions: IDLE -> ACCESS (any request) -> ACK -> IDLE. Always 3 states per transaction.
- Latency:
  - Request seen in IDLE on cycle N gives ack on cycle N+2.
  - Minimum spacing between grants is 3 cycles.
  - A request still asserted in the cycle after its ack is treated as a new request.
- Arbitration:
  - Register last_grant, reset value MCU, so DP wins the first tie.
  - If only one requester is active, it wins.
  - If both are active, the requester not equal to last_grant wins.
  - last_grant updates on entry to ACCESS.
  - A losing request stays pending, with no timeout.
- The winner's request, address, data and we are latched on IDLE->ACCESS. Changes to inputs after that are ignored until ack.
- DP mapping:
  - ram_addr_o = dp_addr_i[10:2].
  - Lane = dp_addr_i[1:0], little-endian (lane 0 = bits 7:0).
  - Write: ram_wd_o = dp byte replicated on all 4 lanes; ram_be_o = one-hot of the lane.
  - Read: dp_data_o = selected byte of ram_rd_i.
- MCU mapping: address, data and be pass through.
  - Write with mcu_be_i=0: ram_we_o stays 0, but the ack is still given.
- ram_we_o is asserted only in ACCESS and only for writes. In every other state ram_we_o=0 and ram_be_o=0.
- Read data outputs:
  - dp_data_o and mcu_data_o are registered from ram_rd_i on ACCESS->ACK.
  - They hold their value until the next read ack.
  - Reset value is 0.
- Reset values: state=IDLE, all acks 0, ram_we_o=0, ram_be_o=0, ram_addr_o=0, ram_wd_o=0, data outputs 0.
- Reset mid-operation:
  - An immediate return to IDLE; no ack is issued.
  - A write already strobed in ACCESS stays in RAM. A read is lost; the requester must re-request.
- The DP address space of 2 KB maps exactly onto 512 words. There are no out-of-range cases and no wrap.

Decomposition:
- Shared package tpm_ram_pkg holds:
  - state enum {IDLE, ACCESS, ACK};
  - grant enum {GNT_DP, GNT_MCU};
  - RAM_WORD_ADDR_WIDTH=9 and the DATA_WIDTH constant.
- One sub-module: tpm_byte_lane, purely combinational.
  - Inputs: lane.
  - Outputs: one-hot byte enable, replicated write word, and the read-byte select.
- Arbiter FSM and registers stay in the top block.

Test Plan:
- DP write 8'hA5 to byte addr 11'h00D -> in ACCESS: ram_addr_o=9'h003, ram_be_o=4'b0010, ram_wd_o=32'hA5A5A5A5; dp_ack_o at N+2.
- MCU write 32'h11223344 be=4'b1111 to word 9'h003, then DP read addr 11'h00E -> dp_data_o=8'h22 on the ack cycle.
- dp_req_i and mcu_req_i asserted in the same cycle out of reset, both held -> DP granted first, MCU second, acks 3 cycles apart; repeat and confirm alternation.
- MCU write with be=4'b0000 -> ram_we_o never asserted, mcu_ack_o pulses once, RAM word unchanged on readback.
- rst_i asserted during ACCESS of a DP read -> no dp_ack_o, all outputs reset next cycle; re-request then completes normally in 2 cycles.
- MCU holds mcu_req_i for continuous back-to-back reads of words 0..511 -> acks every 3 cycles, data matches the RAM model, and the address reaches 9'h1FF without error.
